data_ram_copy_engine: RTL and testbench
=======================================

Name: data_ram_copy_engine

Overview:
- Single-port bus master that drives one port of data_ram: reads a block of words from a source region and writes it to a destination region.
- Sits between control logic (CPU or sequencer) and the data memory; gives block moves without processor load/store traffic.
- Start/busy/done handshake on the control side; read_enable/write_enable/address/write_data/read_data on the memory side.

Parameters:
- ADDR_WIDTH, 17, memory word-address width.
- DATA_WIDTH, 24, memory word width.
- READ_LATENCY, 1, cycles from read-enable cycle to valid mem_read_data (>=1).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- src_addr  in  ADDR_WIDTH  first source word address.
- dst_addr  in  ADDR_WIDTH  first destination word address.
- length  in  ADDR_WIDTH+1  word count; 0 allowed.
- busy  out  1  high in READ/WAIT/WRITE.
- done  out  1  one-cycle pulse at completion.
- words_done  out  ADDR_WIDTH+1  words written in current/last transfer.
- mem_read_enable  out  1  to RAM read_enable.
- mem_write_enable  out  1  to RAM write_enable.
- mem_address  out  ADDR_WIDTH  to RAM address.
- mem_write_data  out  DATA_WIDTH  to RAM write_data.
- mem_read_data  in  DATA_WIDTH  from RAM read_data.

Behaviour:
- Reset (sync, any state): state=IDLE, busy=0, done=0, words_done=0, mem_read_enable=0, mem_write_enable=0, mem_address=0, mem_write_data=0, internal counters/hold register=0. Reset mid-transfer aborts immediately; no done pulse; already-written words stay written.
- States: IDLE, READ, WAIT, WRITE, DONE. Memory-side outputs are decoded from registered state/counters only (Moore); no combinational path from any input to any output.
- IDLE: start=1 at an edge latches src_addr, dst_addr, length (clamped to 2^ADDR_WIDTH if larger); clears words_done. Next state READ if length!=0, else DONE.
- READ (1 cycle): mem_read_enable=1, mem_address=current src. -> WAIT.
- WAIT (READ_LATENCY cycles): all enables 0. At the edge ending the last WAIT cycle, mem_read_data is captured into the hold register. -> WRITE.
- WRITE (1 cycle): mem_write_enable=1, mem_address=current dst, mem_write_data=hold register. At the edge ending WRITE: src+=1, dst+=1 (both mod 2^ADDR_WIDTH, wrap 0x1FFFF->0x00000 at default width), words_done+=1, remaining-=1. -> READ if remaining!=0, else DONE.
- DONE (1 cycle): done=1, busy=0. -> IDLE. Start is ignored in DONE.
- Enables are never both 1 in the same cycle. mem_address and mem_write_data hold their last value when enables are 0.
- Per word: 2+READ_LATENCY cycles. With start sampled at edge E0 and N>0: the READ cycle for word i (0-based) is cycle 1+3i and its WRITE is cycle 3+3i (default latency); done=1 in cycle 3N+1.
- start while busy or in DONE: ignored, no effect on the in-flight transfer.
- Overlapping regions: words are copied strictly ascending, one word at a time. When dst>src and the regions overlap, already-copied data propagates; this is the defined behaviour, not an error.
- words_done holds its final value after done until the next accepted start.

Test Plan:
- Reset values: assert reset 2 cycles mid-idle -> all outputs 0; busy=0, done=0.
- Basic copy: preload RAM[0x00010..0x00013]=0xA00001..0xA00004; start with src=0x00010, dst=0x00100, length=4 -> writes at cycles 3,6,9,12 to 0x00100..0x00103 with matching data; done=1 only in cycle 13; words_done=4; RAM[0x00100..0x00103] matches the source.
- Zero length: start with length=0 -> done=1 in cycle 1; mem_read_enable and mem_write_enable stay 0 throughout; words_done=0.
- Address wrap: src=0x1FFFE, dst=0x1FFFF, length=3 -> read addresses 0x1FFFE, 0x1FFFF, 0x00000; write addresses 0x1FFFF, 0x00000, 0x00001.
- Start while busy: second start pulse with different src/dst during word 1 of a 4-word copy -> ignored; original transfer completes unchanged; exactly one done pulse.
- Reset mid-operation: assert reset in the WAIT cycle of word 2 of a 4-word copy -> next cycle all outputs 0, no done pulse; only words 0–1 written at the destination; a new start afterwards completes normally.

Source files
------------

// File: rtl/data_ram_copy_engine.sv
// Purpose : block copy engine; drives one port of data_ram.
//           It reads words from a source region and writes them to a destination region.
// Latency : 2+READ_LATENCY cycles per word. done pulses 3N+1 cycles after start (default latency).
//           With length 0, done pulses in the cycle after start.
// Backpressure: none on the memory side (fixed-latency RAM). start is accepted only in IDLE.
//
// Ports:
//   i_clock, i_reset        : rising-edge clock, synchronous active-high reset
//   i_start                 : copy request; sampled only while idle
//   i_src_addr, i_dst_addr  : first source / destination word address
//   i_length                : word count (0 allowed, clamped to 2^ADDR_WIDTH)
//   o_busy, o_done          : busy in READ/WAIT/WRITE; one-cycle done pulse
//   o_words_done            : words written in the current/last transfer
//   o_mem_*, i_mem_read_data: RAM read/write port (all outputs registered)
module data_ram_copy_engine #(
  parameter int ADDR_WIDTH   = 17,
  parameter int DATA_WIDTH   = 24,
  parameter int READ_LATENCY = 1
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_src_addr,
  input  logic [ADDR_WIDTH-1:0] i_dst_addr,
  input  logic [ADDR_WIDTH:0]   i_length,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH:0]   o_words_done,
  output logic                  o_mem_read_enable,
  output logic                  o_mem_write_enable,
  output logic [ADDR_WIDTH-1:0] o_mem_address,
  output logic [DATA_WIDTH-1:0] o_mem_write_data,
  input  logic [DATA_WIDTH-1:0] i_mem_read_data
);

  localparam int WCW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [WCW-1:0]        WAIT_LAST = WCW'(READ_LATENCY - 1);
  localparam logic [WCW-1:0]        WAIT_ONE  = WCW'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0]   LEN_MAX   = CNT_ONE << ADDR_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_src;
  logic [ADDR_WIDTH-1:0] r_dst;
  logic [ADDR_WIDTH:0]   r_remaining;
  logic [ADDR_WIDTH:0]   r_words_done;
  logic [WCW-1:0]        r_wait_cnt;
  logic [DATA_WIDTH-1:0] r_hold;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_read_enable;
  logic                  r_write_enable;
  logic [ADDR_WIDTH-1:0] r_mem_address;
  logic [ADDR_WIDTH:0]   w_len;

  // A request larger than the whole address space copies the space once.
  always_comb begin
    w_len = i_length;
    if (i_length > LEN_MAX) begin
      w_len = LEN_MAX;
    end
  end

  // Outputs are computed one cycle ahead from the next state, so every memory-side
  // output is a flop and nothing combinational reaches a port.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state        <= ST_IDLE;
      r_src          <= '0;
      r_dst          <= '0;
      r_remaining    <= '0;
      r_words_done   <= '0;
      r_wait_cnt     <= '0;
      r_hold         <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_read_enable  <= 1'b0;
      r_write_enable <= 1'b0;
      r_mem_address  <= '0;
    end else begin
      r_done         <= 1'b0;
      r_read_enable  <= 1'b0;
      r_write_enable <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_src        <= i_src_addr;
            r_dst        <= i_dst_addr;
            r_remaining  <= w_len;
            r_words_done <= '0;
            if (w_len != '0) begin
              r_state       <= ST_READ;
              r_busy        <= 1'b1;
              r_read_enable <= 1'b1;
              r_mem_address <= i_src_addr;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_READ: begin
          r_state    <= ST_WAIT;
          r_wait_cnt <= '0;
        end
        ST_WAIT: begin
          if (r_wait_cnt == WAIT_LAST) begin
            r_state        <= ST_WRITE;
            r_hold         <= i_mem_read_data;
            r_write_enable <= 1'b1;
            r_mem_address  <= r_dst;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_ONE;
          end
        end
        ST_WRITE: begin
          // Addresses wrap modulo 2^ADDR_WIDTH by natural overflow.
          r_src        <= r_src + ADDR_ONE;
          r_dst        <= r_dst + ADDR_ONE;
          r_words_done <= r_words_done + CNT_ONE;
          r_remaining  <= r_remaining - CNT_ONE;
          if (r_remaining != CNT_ONE) begin
            r_state       <= ST_READ;
            r_read_enable <= 1'b1;
            r_mem_address <= r_src + ADDR_ONE;
          end else begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy             = r_busy;
  assign o_done             = r_done;
  assign o_words_done       = r_words_done;
  assign o_mem_read_enable  = r_read_enable;
  assign o_mem_write_enable = r_write_enable;
  assign o_mem_address      = r_mem_address;
  // The hold register changes only on capture, so write data naturally holds its value.
  assign o_mem_write_data   = r_hold;

endmodule

// File: tb/tb_data_ram_copy_engine.sv
module tb_data_ram_copy_engine;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_start;
  logic [16:0] i_src_addr;
  logic [16:0] i_dst_addr;
  logic [17:0] i_length;
  logic        o_busy;
  logic        o_done;
  logic [17:0] o_words_done;
  logic        o_mem_read_enable;
  logic        o_mem_write_enable;
  logic [16:0] o_mem_address;
  logic [23:0] o_mem_write_data;
  logic [23:0] rdata;

  always #5 clk = ~clk;

  data_ram_copy_engine dut (
    .i_clock           (clk),
    .i_reset           (i_reset),
    .i_start           (i_start),
    .i_src_addr        (i_src_addr),
    .i_dst_addr        (i_dst_addr),
    .i_length          (i_length),
    .o_busy            (o_busy),
    .o_done            (o_done),
    .o_words_done      (o_words_done),
    .o_mem_read_enable (o_mem_read_enable),
    .o_mem_write_enable(o_mem_write_enable),
    .o_mem_address     (o_mem_address),
    .o_mem_write_data  (o_mem_write_data),
    .i_mem_read_data   (rdata)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int base  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Unwritten RAM locations read back as an address-tagged pattern.
  function automatic logic [23:0] pat(input logic [16:0] a);
    return {7'h5B, a};
  endfunction

  logic [23:0] mem    [logic [16:0]];
  logic [23:0] shadow [logic [16:0]];

  function automatic logic [23:0] mem_rd(input logic [16:0] a);
    if (mem.exists(a)) return mem[a];
    return pat(a);
  endfunction

  function automatic logic [23:0] sh_rd(input logic [16:0] a);
    if (shadow.exists(a)) return shadow[a];
    return pat(a);
  endfunction

  // RAM model with a single registered read cycle.
  always @(posedge clk) begin
    if (o_mem_read_enable) rdata <= mem_rd(o_mem_address);
    if (o_mem_write_enable) mem[o_mem_address] = o_mem_write_data;
  end

  // kind: 0 = read, 1 = write, 2 = done
  typedef struct {
    int          kind;
    int          cyc;
    logic [16:0] addr;
    logic [23:0] dat;
  } ev_t;

  ev_t exp_q[$];

  function automatic void push(input int k, input int c, input logic [16:0] a, input logic [23:0] d);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.addr = a;
    e.dat  = d;
    exp_q.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Monitor: every memory access or done pulse is matched against the scoreboard.
  always @(negedge clk) begin
    ev_t         e;
    int          k;
    logic [16:0] a;
    logic [23:0] d;
    if (o_mem_read_enable && o_mem_write_enable) begin
      total++;
      bad++;
      $display("FAIL both_enables: read and write enable both high at cycle %0d", cyc);
    end
    if (o_mem_read_enable || o_mem_write_enable || o_done) begin
      k = o_done ? 2 : (o_mem_write_enable ? 1 : 0);
      a = (k == 2) ? 17'd0 : o_mem_address;
      d = (k == 2) ? 24'(o_words_done) : ((k == 1) ? o_mem_write_data : 24'd0);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: kind=%0d cyc=%0d addr=%h dat=%h, want no event", k, cyc, a, d);
      end else begin
        e = exp_q.pop_front();
        if (e.kind != k || e.cyc != cyc || e.addr != a || e.dat != d || o_busy != (k != 2)) begin
          bad++;
          $display("FAIL event: got kind=%0d cyc=%0d addr=%h dat=%h busy=%0d want kind=%0d cyc=%0d addr=%h dat=%h busy=%0d",
                   k, cyc, a, d, o_busy, e.kind, e.cyc, e.addr, e.dat, (e.kind != 2));
        end
      end
    end
  end

  // Issues one start pulse and queues the expected accesses (events at offset >= stop are not queued).
  task automatic start_xfer(input logic [16:0] s, input logic [16:0] d, input logic [17:0] len, input int stop);
    logic [23:0] v;
    logic [16:0] sa;
    logic [16:0] da;
    @(negedge clk);
    base = cyc;
    i_start    = 1'b1;
    i_src_addr = s;
    i_dst_addr = d;
    i_length   = len;
    for (int i = 0; i < int'(len); i++) begin
      sa = s + 17'(i);
      da = d + 17'(i);
      v  = sh_rd(sa);
      if (1 + 3 * i < stop) push(0, base + 1 + 3 * i, sa, 24'd0);
      if (3 + 3 * i < stop) begin
        push(1, base + 3 + 3 * i, da, v);
        shadow[da] = v;
      end
    end
    if (3 * int'(len) + 1 < stop) push(2, base + 3 * int'(len) + 1, 17'd0, 24'(len));
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic drain(input int n_words);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: %0d events outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
    chk("words_done_hold", 64'(o_words_done), 64'(n_words));
    chk("busy_idle", 64'(o_busy), 64'd0);
  endtask

  task automatic check_ram(input string name, input logic [16:0] d, input int n);
    logic [16:0] a;
    for (int i = 0; i < n; i++) begin
      a = d + 17'(i);
      chk(name, 64'(mem_rd(a)), 64'(sh_rd(a)));
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(o_busy), 64'd0);
    chk({tag, "_done"}, 64'(o_done), 64'd0);
    chk({tag, "_words_done"}, 64'(o_words_done), 64'd0);
    chk({tag, "_rd_en"}, 64'(o_mem_read_enable), 64'd0);
    chk({tag, "_wr_en"}, 64'(o_mem_write_enable), 64'd0);
    chk({tag, "_addr"}, 64'(o_mem_address), 64'd0);
    chk({tag, "_wdata"}, 64'(o_mem_write_data), 64'd0);
  endtask

  initial begin
    i_reset    = 1'b1;
    i_start    = 1'b0;
    i_src_addr = '0;
    i_dst_addr = '0;
    i_length   = '0;
    repeat (3) @(negedge clk);
    i_reset = 1'b0;
    repeat (3) @(negedge clk);

    // Reset held for two cycles while idle.
    i_reset = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    i_reset = 1'b0;
    @(negedge clk);

    // Basic 4-word copy.
    mem[17'h00010] = 24'hA00001; shadow[17'h00010] = 24'hA00001;
    mem[17'h00011] = 24'hA00002; shadow[17'h00011] = 24'hA00002;
    mem[17'h00012] = 24'hA00003; shadow[17'h00012] = 24'hA00003;
    mem[17'h00013] = 24'hA00004; shadow[17'h00013] = 24'hA00004;
    start_xfer(17'h00010, 17'h00100, 18'd4, 1000);
    drain(4);
    chk("basic_w0", 64'(mem_rd(17'h00100)), 64'hA00001);
    chk("basic_w3", 64'(mem_rd(17'h00103)), 64'hA00004);
    check_ram("basic_ram", 17'h00100, 4);

    // Zero length: only a done pulse in cycle 1.
    start_xfer(17'h00200, 17'h00300, 18'd0, 1000);
    drain(0);
    chk("zero_dst_untouched", 64'(mem_rd(17'h00300)), 64'(pat(17'h00300)));

    // Address wrap with overlapping regions: data propagates forward.
    start_xfer(17'h1FFFE, 17'h1FFFF, 18'd3, 1000);
    drain(3);
    chk("wrap_w2", 64'(mem_rd(17'h00001)), 64'(pat(17'h1FFFE)));
    check_ram("wrap_ram", 17'h1FFFF, 3);

    // A second start during word 1 is ignored.
    start_xfer(17'h00400, 17'h00500, 18'd4, 1000);
    while (cyc < base + 4) @(negedge clk);
    i_start    = 1'b1;
    i_src_addr = 17'h00600;
    i_dst_addr = 17'h00700;
    i_length   = 18'd2;
    @(negedge clk);
    i_start = 1'b0;
    drain(4);
    check_ram("busy_ram", 17'h00500, 4);
    chk("busy_ignored_dst", 64'(mem_rd(17'h00700)), 64'(pat(17'h00700)));

    // Reset during the WAIT cycle of word 2 (cycle 8): no further events.
    start_xfer(17'h00800, 17'h00900, 18'd4, 9);
    while (cyc < base + 8) @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    i_reset = 1'b0;
    repeat (20) @(negedge clk);
    drain(0);
    check_ram("midreset_ram", 17'h00900, 4);
    chk("midreset_w1", 64'(mem_rd(17'h00901)), 64'(pat(17'h00801)));
    chk("midreset_w2", 64'(mem_rd(17'h00902)), 64'(pat(17'h00902)));

    // Normal operation after the aborted transfer.
    start_xfer(17'h00A00, 17'h00B00, 18'd2, 1000);
    drain(2);
    check_ram("restart_ram", 17'h00B00, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
